// File: rtl/pcie_dllp_crc_stream.sv
// Streaming CRC-16 (MSB-first, left shift) over a byte stream with keep-masked last beat.
// Define PCIE_DLLP_CRC_BITMAP_EN to present crc_o in PCIe wire bit mapping (complemented, bytes bit-reversed).
module pcie_dllp_crc_stream #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter logic [15:0] POLY       = 16'h100B,
  parameter logic [15:0] INIT       = 16'hFFFF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] s_tdata_i,
  input  logic [KEEP_WIDTH-1:0] s_tkeep_i,
  input  logic                  s_tvalid_i,
  input  logic                  s_tlast_i,
  output logic                  s_tready_o,
  output logic [15:0]           crc_o,
  output logic                  crc_valid_o,
  input  logic                  crc_ready_i,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_crc;
  logic [15:0] r_crc_out;
  logic [15:0] w_crc_calc;
  logic [15:0] w_crc_fin;
  logic        w_accept;

  // r_crc is back at INIT whenever no frame is open, so it is always the correct seed.
  always_comb begin : crc_update
    logic [15:0] c;
    logic [7:0]  b;
    logic        en;
    logic        fb;
    c  = r_crc;
    b  = '0;
    en = 1'b1;
    fb = 1'b0;
    for (int unsigned l = 0; l < KEEP_WIDTH; l++) begin
      if (s_tlast_i && !s_tkeep_i[l]) en = 1'b0;
      b = s_tdata_i[8*l +: 8];
      for (int unsigned k = 0; k < 8; k++) begin
        fb = c[15] ^ b[7];
        b  = {b[6:0], 1'b0};
        if (en) c = fb ? ({c[14:0], 1'b0} ^ POLY) : {c[14:0], 1'b0};
      end
    end
    w_crc_calc = c;
  end

`ifdef PCIE_DLLP_CRC_BITMAP_EN
  assign w_crc_fin = ~{w_crc_calc[8],  w_crc_calc[9],  w_crc_calc[10], w_crc_calc[11],
                       w_crc_calc[12], w_crc_calc[13], w_crc_calc[14], w_crc_calc[15],
                       w_crc_calc[0],  w_crc_calc[1],  w_crc_calc[2],  w_crc_calc[3],
                       w_crc_calc[4],  w_crc_calc[5],  w_crc_calc[6],  w_crc_calc[7]};
`else
  assign w_crc_fin = w_crc_calc;
`endif

  assign w_accept = s_tvalid_i && s_tready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_crc     <= INIT;
      r_crc_out <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        if (s_tlast_i) begin
          r_crc     <= INIT;
          r_crc_out <= w_crc_fin;
        end else begin
          r_crc <= w_crc_calc;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    s_tready_o  = 1'b0;
    crc_valid_o = 1'b0;
    busy_o      = 1'b0;
    case (r_state)
      IDLE: begin
        s_tready_o = !rst_i;
        if (w_accept) w_state_nxt = s_tlast_i ? DONE : ACCUM;
      end
      ACCUM: begin
        s_tready_o = !rst_i;
        busy_o     = 1'b1;
        if (w_accept && s_tlast_i) w_state_nxt = DONE;
      end
      DONE: begin
        s_tready_o  = !rst_i && crc_ready_i;
        crc_valid_o = 1'b1;
        if (w_accept)         w_state_nxt = s_tlast_i ? DONE : ACCUM;
        else if (crc_ready_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign crc_o = r_crc_out;

endmodule

// File: tb/tb_pcie_dllp_crc_stream.sv
// Randomized self-checking bench for pcie_dllp_crc_stream against a byte-queue CRC model.
module tb_pcie_dllp_crc_stream;
  localparam int DW = 32;
  localparam int KW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_tdata_i;
  logic [KW-1:0] s_tkeep_i;
  logic          s_tvalid_i;
  logic          s_tlast_i;
  logic          s_tready_o;
  logic [15:0]   crc_o;
  logic          crc_valid_o;
  logic          crc_ready_i;
  logic          busy_o;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;
  int npush  = 0;
  int npop   = 0;
  int consec = 0;
  int last_pop_cyc = -10;
  int last_wait    = 0;
  int rdy_mode     = 1;  // 0 random, 1 high, 2 low

  logic [15:0] exp_q[$];
  logic [7:0]  cur[$];

  pcie_dllp_crc_stream #(
    .DATA_WIDTH(DW),
    .POLY      (16'h100B),
    .INIT      (16'hFFFF)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .s_tdata_i  (s_tdata_i),
    .s_tkeep_i  (s_tkeep_i),
    .s_tvalid_i (s_tvalid_i),
    .s_tlast_i  (s_tlast_i),
    .s_tready_o (s_tready_o),
    .crc_o      (crc_o),
    .crc_valid_o(crc_valid_o),
    .crc_ready_i(crc_ready_i),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Bit-serial CRC over a byte list, then optional wire mapping.
  function automatic logic [15:0] ref_crc(input logic [7:0] bq[$]);
    logic [15:0] c;
    logic [15:0] o;
    logic        fb;
    c = 16'hFFFF;
    foreach (bq[i]) begin
      for (int k = 0; k < 8; k++) begin
        fb = c[15] ^ bq[i][7-k];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h100B;
      end
    end
`ifdef PCIE_DLLP_CRC_BITMAP_EN
    for (int i = 0; i < 8; i++) begin
      o[i]   = ~c[7-i];
      o[i+8] = ~c[15-i];
    end
`else
    o = c;
`endif
    return o;
  endfunction

  initial begin
    crc_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       crc_ready_i = ($urandom_range(0, 3) != 0);
        1:       crc_ready_i = 1'b1;
        default: crc_ready_i = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst && crc_valid_o && crc_ready_i) begin
      if (exp_q.size() == 0) chk("unexpected_result", 32'(crc_o), 32'hDEAD);
      else                   chk("frame_crc", 32'(crc_o), 32'(exp_q.pop_front()));
      npop++;
      consec       = (cyc == last_pop_cyc + 1) ? consec + 1 : 1;
      last_pop_cyc = cyc;
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    int   waitc;
    int   n;
    logic acc;
    s_tdata_i  = d;
    s_tkeep_i  = k;
    s_tlast_i  = l;
    s_tvalid_i = 1'b1;
    waitc = 0;
    acc   = 1'b0;
    while (!acc && waitc < 50) begin
      @(negedge clk);
      acc = s_tready_o && !rst;
      @(posedge clk);
      #1;
      if (!acc) waitc++;
    end
    s_tvalid_i = 1'b0;
    last_wait  = waitc;
    if (!acc) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      n = KW;
      if (l) begin
        n = 0;
        while (n < KW && k[n]) n++;
      end
      for (int i = 0; i < n; i++) cur.push_back(d[8*i +: 8]);
      if (l) begin
        exp_q.push_back(ref_crc(cur));
        npush++;
        cur.delete();
      end
    end
  endtask

  task automatic set_mode(input int m);
    rdy_mode = m;
    repeat (2) @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    s_tdata_i = '0; s_tkeep_i = '0; s_tvalid_i = 1'b0; s_tlast_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_crc_o", 32'(crc_o), 32'h0);
    chk("rst_valid", 32'(crc_valid_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_tready", 32'(s_tready_o), 32'h0);
    rst = 1'b0;
    #1;
    chk("idle_tready", 32'(s_tready_o), 32'h1);
    chk("idle_busy", 32'(busy_o), 32'h0);

    // Single DLLP: zero data, full keep, result one cycle after acceptance
    set_mode(1);
    chk("pre_valid", 32'(crc_valid_o), 32'h0);
    send_beat(32'h0000_0000, 4'hF, 1'b1);
    chk("latency_valid", 32'(crc_valid_o), 32'h1);
    chk("latency_crc", 32'(crc_o), 32'(exp_q[$]));
    repeat (3) @(posedge clk);
    #1;

    // Split frame 01..06 with partial last beat
    send_beat(32'h0403_0201, 4'hF, 1'b0);
    chk("split_busy", 32'(busy_o), 32'h1);
    send_beat(32'hABCD_0605, 4'b0011, 1'b1);
    begin
      logic [7:0] ref6[$];
      for (int i = 1; i <= 6; i++) ref6.push_back(8'(i));
      chk("split_crc", 32'(crc_o), 32'(ref_crc(ref6)));
    end
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: result held, input stalled
    set_mode(2);
    send_beat($urandom, 4'hF, 1'b1);
    s_tdata_i = $urandom; s_tkeep_i = 4'hF; s_tlast_i = 1'b1; s_tvalid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(crc_valid_o), 32'h1);
      chk("bp_crc", 32'(crc_o), 32'(exp_q[$]));
      chk("bp_tready", 32'(s_tready_o), 32'h0);
      chk("bp_busy", 32'(busy_o), 32'h0);
    end
    s_tvalid_i = 1'b0;
    set_mode(1);
    send_beat($urandom, 4'hF, 1'b0);
    send_beat($urandom, 4'h7, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back single-beat frames
    for (int f = 0; f < 4; f++) begin
      send_beat($urandom, 4'hF, 1'b1);
      if (f > 0) chk("b2b_no_stall", 32'(last_wait), 32'h0);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("b2b_consecutive", 32'(consec), 32'd4);

    // Reset between beats 1 and 2 of a 3-beat frame
    send_beat($urandom, 4'hF, 1'b0);
    chk("mid_busy", 32'(busy_o), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(crc_valid_o), 32'h0);
    chk("mid_rst_busy", 32'(busy_o), 32'h0);
    chk("mid_rst_tready", 32'(s_tready_o), 32'h0);
    chk("mid_rst_crc", 32'(crc_o), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cur.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("mid_no_result", 32'(crc_valid_o), 32'h0);
    for (int b = 0; b < 3; b++) send_beat($urandom, 4'hF, b == 2);

    // Keep corner cases: empty last beat, non-contiguous keep
    send_beat($urandom, 4'h0, 1'b1);
    send_beat($urandom, 4'hF, 1'b0);
    send_beat($urandom, 4'b1011, 1'b1);
    send_beat($urandom, 4'b1101, 1'b1);

    // Random frames with random keep, gaps and result backpressure
    set_mode(0);
    for (int f = 0; f < 60; f++) begin
      int nb;
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
        send_beat($urandom, KW'($urandom), b == nb - 1);
      end
    end

    set_mode(1);
    repeat (10) @(posedge clk);
    #1;
    chk("drain_empty", 32'(exp_q.size()), 32'h0);
    chk("result_count", 32'(npop), 32'(npush));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1);
  end
endmodule

// File: doc/pcie_dllp_crc_stream.md
Name: pcie_dllp_crc_stream

Overview:
- Streaming, pipelined CRC-16 engine for the PCIe data link layer.
- Accumulates CRC across a multi-beat byte stream of parametrised width, with partial last beat via byte keep and valid/ready flow control on input and result.
- Successor to the fixed 32-bit combinational DLLP CRC: adds beat width, per-lane keep masking, frame state and registered output.
- Sits between DLLP/TLP framing logic and the CRC insert/check stage.

Parameters:
- DATA_WIDTH, 32, input beat width in bits; multiple of 8, range 8..128.
- KEEP_WIDTH, DATA_WIDTH/8, byte lanes per beat.
- POLY, 16'h100B, CRC-16 polynomial, MSB-first (left shift), implicit x^16.
- INIT, 16'hFFFF, CRC seed loaded at the start of each frame.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  asynchronous, active-high reset.
- s_tdata_i  input  DATA_WIDTH  frame bytes; lane 0 (bits 7:0) is processed first.
- s_tkeep_i  input  KEEP_WIDTH  lane valid mask; only sampled on the last beat.
- s_tvalid_i  input  1  beat valid.
- s_tlast_i  input  1  final beat of frame.
- s_tready_o  output  1  engine accepts a beat.
- crc_o  output  16  frame CRC result.
- crc_valid_o  output  1  crc_o valid.
- crc_ready_i  input  1  consumer accepts crc_o.
- busy_o  output  1  a frame is in progress (at least one beat accepted, result not yet produced).

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is asynchronous and active-high.
- Reset values:
  - crc_o = 16'h0000, crc_valid_o = 0, busy_o = 0, s_tready_o = 0 while rst_i is high.
  - Internal running CRC is INIT; state is IDLE.
- Beat transfer: a beat is accepted when s_tvalid_i && s_tready_o on a clk_i rising edge.
- Per-byte update, for each processed byte b:
  - The CRC is left-shifted 8 times, one bit per step.
  - Feedback bit = crc[15] ^ b[7-k] for k = 0..7 (byte MSB first).
  - If feedback is 1, XOR with POLY.
  - Lanes are chained in ascending lane order within a beat.
- Non-last beats: all KEEP_WIDTH lanes are processed; s_tkeep_i is ignored.
- Last beat:
  - Only lanes with keep=1 are processed. Keep must be contiguous from lane 0.
  - Non-contiguous keep: lanes above the first 0 are dropped.
  - keep = 0 on the last beat: no bytes are added.
- States:
  - IDLE: running CRC = INIT; s_tready_o = 1.
    - Non-last beat accepted -> ACCUM, running CRC updated.
    - Last beat accepted -> DONE.
  - ACCUM: s_tready_o = 1; busy_o = 1.
    - Non-last beat -> stay in ACCUM.
    - Last beat -> DONE.
  - DONE: crc_valid_o = 1; crc_o holds the final CRC; s_tready_o = crc_ready_i.
    - crc_ready_i = 1 with no new beat -> IDLE.
    - crc_ready_i = 1 and a new beat is accepted in the same cycle -> the beat starts a fresh frame from INIT (ACCUM, or DONE again if it is last). The new result replaces crc_o on the next edge.
- Latency and throughput:
  - crc_valid_o rises one cycle after the last beat is accepted.
  - Back-to-back frames sustain one beat per cycle when crc_ready_i stays high.
- Backpressure: with crc_valid_o = 1 and crc_ready_i = 0, crc_o and crc_valid_o hold stable and s_tready_o = 0.
- Reset mid-frame: the frame is discarded. No crc_valid_o pulse is produced for it after reset.
- Width rule: the combinational update depth is KEEP_WIDTH bytes per cycle. No multicycle paths.

Optional Feature:
- Macro: PCIE_DLLP_CRC_BITMAP_EN.
- Defined: crc_o is the PCIe wire mapping of the final CRC.
  - The final CRC is complemented.
  - Within each byte, the bit order is reversed: out[i] = ~crc[7-i] and out[i+8] = ~crc[15-i] for i = 0..7.
- Undefined: crc_o is the raw final register with no inversion or reversal.
- Timing and handshake are identical in both builds.

Test Plan:
- Single DLLP: one beat, DATA_WIDTH=32, data 32'h0000_0000, keep 4'hF, last=1 -> crc_valid_o high exactly 1 cycle later; crc_o equals the bit-serial reference model (POLY 100B, INIT FFFF) on bytes 00,00,00,00.
- Split-frame equivalence: 6 bytes 01..06 sent as beat 04030201 (last=0) then beat xxxx0605 with keep 4'b0011 (last=1) -> crc_o equals the model over 01..06. The same result is required from DATA_WIDTH=16 with three full beats.
- Backpressure: crc_ready_i=0 for 5 cycles after DONE -> crc_o and crc_valid_o are stable, s_tready_o=0, and an offered beat is not accepted. crc_ready_i=1 -> the next frame starts from INIT.
- Back-to-back: 4 single-beat frames on consecutive cycles with crc_ready_i=1 -> 4 consecutive crc_valid_o cycles, each crc_o matching its own frame (no carry-over).
- Reset mid-frame: assert rst_i asynchronously between beats 1 and 2 of a 3-beat frame -> outputs reset immediately; the next frame's crc_o matches the model seeded with INIT.
- Bitmap feature: the single-DLLP vector rerun with PCIE_DLLP_CRC_BITMAP_EN defined -> crc_o equals the per-byte bit-reversed complement of the undefined-build value.
